branch_counter_predictor: RTL and testbench

Parametrised direction predictor that replaces the fixed 128-entry 2-bit bimodal predictor. It supports N-bit saturating counters, a configurable table depth, and an optional global-history (gshare) index mode with speculative history update and repair on mispredict. It sits beside the fetch-stage BTB: it is looked up with the fetch PC and trained from the resolving stage (M). Its mispredict output drives the pipeline flush.

---
 rtl/bp_pkg.sv | 28 ++
 rtl/bp_counter_table.sv | 43 ++++
 rtl/branch_counter_predictor.sv | 77 +++++++
 tb/tb_branch_counter_predictor.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch direction predictor.
package bp_pkg;

    // Widest supported counter; narrower tables cast in and out of this.
    localparam int CTR_MAX_BITS = 4;
    typedef logic [CTR_MAX_BITS-1:0] ctr_t;

    // Weakly not-taken: one below the taken threshold.
    function automatic int ctr_init_default(input int ctr_bits);
        return (1 << (ctr_bits - 1)) - 1;
    endfunction

    // Word-aligned PC XOR zero-extended history; caller truncates to index width.
    function automatic logic [31:0] bp_hash(input logic [31:0] pc, input logic [31:0] hist);
        return {2'b00, pc[31:2]} ^ hist;
    endfunction

    // Saturating step toward the resolved direction.
    function automatic ctr_t sat_next(input ctr_t ctr, input logic taken, input int ctr_bits);
        ctr_t top;
        top = ctr_t'((1 << ctr_bits) - 1);
        if (taken)
            return (ctr == top) ? ctr : ctr + 1'b1;
        else
            return (ctr == '0) ? ctr : ctr - 1'b1;
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Counter storage: one combinational read port, one saturating write port.
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int CTR_BITS   = 2,
    parameter int INDEX_BITS = 7,
    parameter int CTR_INIT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_taken,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic                  wr_taken
);

    localparam int DEPTH = 1 << INDEX_BITS;

    logic [CTR_BITS-1:0] ctr_q [DEPTH];
    logic [CTR_BITS-1:0] ctr_d [DEPTH];

    // Next table state: only the trained entry moves.
    always_comb begin
        ctr_d = ctr_q;
        if (wr_en)
            ctr_d[wr_idx] = CTR_BITS'(sat_next(ctr_t'(ctr_q[wr_idx]), wr_taken, CTR_BITS));
    end

    // Storage; reset overrides any write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                ctr_q[i] <= CTR_BITS'(CTR_INIT);
        end else begin
            ctr_q <= ctr_d;
        end
    end

    // Read returns pre-update state; no write bypass.
    assign rd_taken = ctr_q[rd_idx][CTR_BITS-1];

endmodule

// File: rtl/branch_counter_predictor.sv
// Direction predictor: bimodal or gshare indexing, speculative history with repair.
module branch_counter_predictor
    import bp_pkg::*;
#(
    parameter int CTR_BITS   = 2,
    parameter int INDEX_BITS = 7,
    parameter int HIST_BITS  = 7,
    parameter int GSHARE     = 1,
    parameter int CTR_INIT   = ctr_init_default(CTR_BITS),
    localparam int HW        = (HIST_BITS > 0) ? HIST_BITS : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   PC,
    input  logic          lookup_branch,
    output logic          predicted_dir,
    output logic [HW-1:0] pred_hist,
    input  logic          res_valid,
    input  logic [31:0]   BPC,
    input  logic [HW-1:0] res_hist,
    input  logic          res_pred,
    input  logic          actual_result,
    output logic          flush_pipeline,
    output logic [HW-1:0] ghr
);

    // History only participates when gshare is on and has length.
    localparam bit USE_HIST = (GSHARE != 0) && (HIST_BITS > 0);

    logic [HW-1:0]         ghr_q, ghr_d;
    logic [HW-1:0]         look_hist, train_hist;
    logic [INDEX_BITS-1:0] idx_f, idx_r;

    assign look_hist  = USE_HIST ? ghr_q    : '0;
    assign train_hist = USE_HIST ? res_hist : '0;

    assign idx_f = INDEX_BITS'(bp_hash(PC,  32'(look_hist)));
    assign idx_r = INDEX_BITS'(bp_hash(BPC, 32'(train_hist)));

    assign flush_pipeline = res_valid & (res_pred ^ actual_result);
    assign pred_hist      = look_hist;
    assign ghr            = ghr_q;

    // History next-state: repair beats speculative shift (that fetch is flushed).
    always_comb begin
        ghr_d = ghr_q;
        if (!USE_HIST)
            ghr_d = '0;
        else if (flush_pipeline)
            ghr_d = HW'({res_hist, actual_result});
        else if (lookup_branch)
            ghr_d = HW'({ghr_q, predicted_dir});
    end

    // History register.
    always_ff @(posedge clk) begin
        if (rst)
            ghr_q <= '0;
        else
            ghr_q <= ghr_d;
    end

    bp_counter_table #(
        .CTR_BITS   (CTR_BITS),
        .INDEX_BITS (INDEX_BITS),
        .CTR_INIT   (CTR_INIT)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (idx_f),
        .rd_taken (predicted_dir),
        .wr_en    (res_valid),
        .wr_idx   (idx_r),
        .wr_taken (actual_result)
    );

endmodule

// File: tb/tb_branch_counter_predictor.sv
// Three predictor configurations driven in lockstep against a reference model.
module tb_branch_counter_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC, BPC;
    logic        lookup_branch, res_valid, res_pred, actual_result;
    logic [6:0]  res_hist;

    logic [2:0]      pd, fl;
    logic [2:0][6:0] phs, gh;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // u0: default gshare, u1: bimodal 2-bit, u2: bimodal 3-bit
    branch_counter_predictor u0 (
        .clk(clk), .rst(rst), .PC(PC), .lookup_branch(lookup_branch),
        .predicted_dir(pd[0]), .pred_hist(phs[0]), .res_valid(res_valid), .BPC(BPC),
        .res_hist(res_hist), .res_pred(res_pred), .actual_result(actual_result),
        .flush_pipeline(fl[0]), .ghr(gh[0]));

    branch_counter_predictor #(.GSHARE(0)) u1 (
        .clk(clk), .rst(rst), .PC(PC), .lookup_branch(lookup_branch),
        .predicted_dir(pd[1]), .pred_hist(phs[1]), .res_valid(res_valid), .BPC(BPC),
        .res_hist(res_hist), .res_pred(res_pred), .actual_result(actual_result),
        .flush_pipeline(fl[1]), .ghr(gh[1]));

    branch_counter_predictor #(.CTR_BITS(3), .GSHARE(0)) u2 (
        .clk(clk), .rst(rst), .PC(PC), .lookup_branch(lookup_branch),
        .predicted_dir(pd[2]), .pred_hist(phs[2]), .res_valid(res_valid), .BPC(BPC),
        .res_hist(res_hist), .res_pred(res_pred), .actual_result(actual_result),
        .flush_pipeline(fl[2]), .ghr(gh[2]));

    // Reference model
    int         ctrbits [3] = '{2, 2, 3};
    bit         gsh     [3] = '{1'b1, 1'b0, 1'b0};
    int         mt      [3][128];
    logic [6:0] mg      [3];

    typedef struct {
        int         inst;
        logic       pdir;
        logic [6:0] hist;
        logic       flush;
        logic [6:0] ghr;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int midx(input int k, input logic [31:0] pc, input logic [6:0] h);
        logic [31:0] v;
        v = (pc >> 2) ^ (gsh[k] ? {25'b0, h} : 32'b0);
        return int'(v[6:0]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 128; i++) mt[k][i] = (1 << (ctrbits[k] - 1)) - 1;
            mg[k] = '0;
        end
    endtask

    // One clock of stimulus: drive, score combinational outputs, advance model.
    task automatic cyc(input bit r, input bit lb, input bit rv, input logic [31:0] pc,
                       input logic [31:0] bpc, input logic [6:0] rh, input bit rp, input bit ar);
        exp_t e;
        logic ep [3];
        bit   flush;
        int   i, top;
        rst = r; lookup_branch = lb; res_valid = rv; PC = pc; BPC = bpc;
        res_hist = rh; res_pred = rp; actual_result = ar;
        flush = rv && (rp != ar);
        for (int k = 0; k < 3; k++) begin
            ep[k]   = ((mt[k][midx(k, pc, mg[k])] >> (ctrbits[k] - 1)) & 1) != 0;
            e.inst  = k;
            e.pdir  = ep[k];
            e.hist  = mg[k];
            e.flush = flush;
            e.ghr   = mg[k];
            sbq.push_back(e);
        end
        #3;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk($sformatf("pdir%0d", e.inst),  32'(pd[e.inst]),  32'(e.pdir));
            chk($sformatf("phist%0d", e.inst), 32'(phs[e.inst]), 32'(e.hist));
            chk($sformatf("flush%0d", e.inst), 32'(fl[e.inst]),  32'(e.flush));
            chk($sformatf("ghr%0d", e.inst),   32'(gh[e.inst]),  32'(e.ghr));
        end
        if (r) begin
            model_reset();
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (rv) begin
                    i   = midx(k, bpc, rh);
                    top = (1 << ctrbits[k]) - 1;
                    if (ar) mt[k][i] = (mt[k][i] == top) ? top : mt[k][i] + 1;
                    else    mt[k][i] = (mt[k][i] == 0)   ? 0   : mt[k][i] - 1;
                end
                if (gsh[k]) begin
                    if (flush)   mg[k] = {rh[5:0], ar};
                    else if (lb) mg[k] = {mg[k][5:0], ep[k]};
                end
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; lookup_branch = 0; res_valid = 0; PC = 0; BPC = 0;
        res_hist = 0; res_pred = 0; actual_result = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state
        cyc(0, 0, 0, 32'h40, 32'h0, 7'h0, 0, 0);
        #1;
        chk("rst_pdir", 32'(pd[0]), 32'd0);
        chk("rst_ghr",  32'(gh[0]), 32'd0);
        chk("rst_fl",   32'(fl[0]), 32'd0);

        // Taken training at 0x40: 1 -> 2 -> 3 -> 3, then one not-taken -> 2
        cyc(0, 0, 1, 32'h40, 32'h40, 7'h0, 0, 1);
        #1; chk("bim_first_taken", 32'(pd[1]), 32'd1);
        repeat (3) cyc(0, 0, 1, 32'h40, 32'h40, 7'h0, 1, 1);
        cyc(0, 0, 1, 32'h40, 32'h40, 7'h0, 1, 0);
        #1; chk("bim_sat_then_nt", 32'(pd[1]), 32'd1);

        // 3-bit: 5 taken from 3 saturates at 7, then 4 not-taken -> 3
        repeat (5) cyc(0, 0, 1, 32'h80, 32'h80, 7'h0, 1, 1);
        repeat (4) cyc(0, 0, 1, 32'h80, 32'h80, 7'h0, 0, 0);
        #1; chk("c3_back_to_3", 32'(pd[2]), 32'd0);

        // Gshare speculative shift of not-taken predictions, then repair
        cyc(1, 0, 0, 32'h100, 32'h0, 7'h0, 0, 0);
        repeat (3) cyc(0, 1, 0, 32'h100, 32'h0, 7'h0, 0, 0);
        #1; chk("gs_shift_zero", 32'(gh[0]), 32'd0);
        cyc(0, 0, 1, 32'h100, 32'h200, 7'b0000101, 0, 1);
        #1; chk("gs_repair", 32'(gh[0]), 32'(7'b0001011));

        // Repair with simultaneous lookup_branch: no extra shift
        cyc(0, 1, 1, 32'h100, 32'h200, 7'b0010000, 1, 0);
        #1; chk("gs_repair_lb", 32'(gh[0]), 32'(7'b0100000));

        // Reset dominates a same-cycle train
        cyc(0, 1, 1, 32'h40, 32'h40, 7'h0, 0, 1);
        cyc(1, 1, 1, 32'h40, 32'h40, 7'h0, 0, 1);
        #1;
        chk("rst_blocks_wr", 32'(pd[1]), 32'd0);
        chk("rst_ghr_zero",  32'(gh[0]), 32'd0);

        // Random traffic over a small PC window to force aliasing and collisions
        for (int n = 0; n < 400; n++) begin
            logic [31:0] rpc, rbpc;
            rpc  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            rbpc = $urandom_range(0, 3) == 0 ? rpc : {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            cyc($urandom_range(0, 63) == 0, 1'($urandom), 1'($urandom), rpc, rbpc,
                7'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
